// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: scan request in, sync/blanking/coordinate/strobe outputs.
interface vga_timing_gen_if #(
  parameter int XW = 11,
  parameter int YW = 11
);
  logic          Run;
  logic          HS;
  logic          VS;
  logic          HBlank;
  logic          VBlank;
  logic          Active;
  logic [XW-1:0] CurrentX;
  logic [YW-1:0] CurrentY;
  logic          PixelEn;
  logic          LineStart;
  logic          FrameStart;
  logic          Running;

  modport master (
    input  Run,
    output HS, VS, HBlank, VBlank, Active, CurrentX, CurrentY,
    output PixelEn, LineStart, FrameStart, Running
  );

  modport slave (
    output Run,
    input  HS, VS, HBlank, VBlank, Active, CurrentX, CurrentY,
    input  PixelEn, LineStart, FrameStart, Running
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/SVGA raster timing generator with frame-aligned run/stop.
module vga_timing_gen #(
  parameter int CLKDIV   = 2,
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 56,
  parameter int H_SYNC   = 120,
  parameter int H_BP     = 64,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 37,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 23,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int XW       = 11,
  parameter int YW       = 11
) (
  input logic              CLK_100MHz,
  input logic              Reset,
  vga_timing_gen_if.master bus
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_STOP  = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_STOP  = VS_START + V_SYNC;
  localparam int DW       = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [DW-1:0] div_cnt;
  logic [XW-1:0] h;
  logic [YW-1:0] v;
  logic          tick;
  logic          h_last;
  logic          v_last;
  logic          frame_wrap;
  logic          hs_c;
  logic          vs_c;
  logic          hb_c;
  logic          vb_c;
  logic          pe_c;

  assign tick       = (div_cnt == DW'(CLKDIV - 1));
  assign h_last     = (h == XW'(H_TOTAL - 1));
  assign v_last     = (v == YW'(V_TOTAL - 1));
  assign frame_wrap = tick && h_last && v_last;

  // Next state: a stop request only takes effect on the tick that closes the frame.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (bus.Run) state_nxt = RUN;
      RUN:      if (!bus.Run) state_nxt = STOPPING;
      STOPPING: begin
        if (bus.Run)         state_nxt = RUN;
        else if (frame_wrap) state_nxt = IDLE;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK_100MHz) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Pixel divider and raster counters; held at zero while idle.
  always_ff @(posedge CLK_100MHz) begin
    if (Reset || state == IDLE) begin
      div_cnt <= '0;
      h       <= '0;
      v       <= '0;
    end else if (tick) begin
      div_cnt <= '0;
      if (h_last) begin
        h <= '0;
        v <= v_last ? '0 : v + YW'(1);
      end else begin
        h <= h + XW'(1);
      end
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // Decode of the raster position currently held in the counters.
  always_comb begin
    hs_c = (h >= XW'(HS_START) && h < XW'(HS_STOP)) ? HS_POL : ~HS_POL;
    vs_c = (v >= YW'(VS_START) && v < YW'(VS_STOP)) ? VS_POL : ~VS_POL;
    hb_c = (h >= XW'(H_ACTIVE));
    vb_c = (v >= YW'(V_ACTIVE));
    pe_c = (div_cnt == '0);
  end

  // Output registers: the counters are one edge ahead, so the outputs land on
  // the edge the raster enters each position and fall back to idle levels on
  // the edge that would have shown (0,0) after a stop.
  always_ff @(posedge CLK_100MHz) begin
    if (Reset || state == IDLE) begin
      bus.HS         <= ~HS_POL;
      bus.VS         <= ~VS_POL;
      bus.HBlank     <= 1'b1;
      bus.VBlank     <= 1'b1;
      bus.Active     <= 1'b0;
      bus.CurrentX   <= '0;
      bus.CurrentY   <= '0;
      bus.PixelEn    <= 1'b0;
      bus.LineStart  <= 1'b0;
      bus.FrameStart <= 1'b0;
      bus.Running    <= 1'b0;
    end else begin
      bus.HS         <= hs_c;
      bus.VS         <= vs_c;
      bus.HBlank     <= hb_c;
      bus.VBlank     <= vb_c;
      bus.Active     <= ~hb_c & ~vb_c;
      bus.CurrentX   <= h;
      bus.CurrentY   <= v;
      bus.PixelEn    <= pe_c;
      bus.LineStart  <= pe_c && (h == '0);
      bus.FrameStart <= pe_c && (h == '0) && (v == '0);
      bus.Running    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three parameterisations checked every clock against
// an arithmetic raster model, plus a vector table and directed sequences.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst;
  logic run_req [3];

  always #5 clk = ~clk;

  vga_timing_gen_if #(.XW(11), .YW(11)) if_a ();
  vga_timing_gen_if #(.XW(11), .YW(11)) if_b ();
  vga_timing_gen_if #(.XW(11), .YW(11)) if_c ();

  assign if_a.Run = run_req[0];
  assign if_b.Run = run_req[1];
  assign if_c.Run = run_req[2];

  vga_timing_gen #(
    .CLKDIV(2), .H_ACTIVE(16), .H_FP(3), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .HS_POL(1'b0), .VS_POL(1'b0), .XW(11), .YW(11)
  ) dut_a (.CLK_100MHz(clk), .Reset(rst), .bus(if_a));

  vga_timing_gen #(
    .CLKDIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .XW(11), .YW(11)
  ) dut_b (.CLK_100MHz(clk), .Reset(rst), .bus(if_b));

  vga_timing_gen #(.XW(11), .YW(11)) dut_c (.CLK_100MHz(clk), .Reset(rst), .bus(if_c));

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic        act;
    logic [10:0] x;
    logic [10:0] y;
    logic        pe;
    logic        ls;
    logic        fs;
    logic        run;
  } obs_t;

  typedef struct {
    int div, ha, hf, hsw, hbp, va, vf, vsw, vbp;
    bit hp, vp;
  } cfg_t;

  typedef struct {
    bit rst;
    bit run;
    bit hs;
    bit vs;
    int x;
    int y;
    bit pe;
    bit fs;
    bit running;
  } vec_t;

  obs_t dut_obs [3];
  assign dut_obs[0] = {if_a.HS, if_a.VS, if_a.HBlank, if_a.VBlank, if_a.Active, if_a.CurrentX,
                       if_a.CurrentY, if_a.PixelEn, if_a.LineStart, if_a.FrameStart, if_a.Running};
  assign dut_obs[1] = {if_b.HS, if_b.VS, if_b.HBlank, if_b.VBlank, if_b.Active, if_b.CurrentX,
                       if_b.CurrentY, if_b.PixelEn, if_b.LineStart, if_b.FrameStart, if_b.Running};
  assign dut_obs[2] = {if_c.HS, if_c.VS, if_c.HBlank, if_c.VBlank, if_c.Active, if_c.CurrentX,
                       if_c.CurrentY, if_c.PixelEn, if_c.LineStart, if_c.FrameStart, if_c.Running};

  cfg_t cfg [3];
  int   errors = 0;
  int   checks = 0;
  bit   chk_en = 1'b0;

  // Model state: mode 0 idle, 1 start requested, 2 scanning; t counts clocks into the frame.
  int   m_mode [3];
  int   m_t    [3];
  bit   m_prev [3];
  obs_t m_exp  [3];

  function automatic int frame_len(input cfg_t c);
    return c.div * (c.ha + c.hf + c.hsw + c.hbp) * (c.va + c.vf + c.vsw + c.vbp);
  endfunction

  function automatic obs_t idle_obs(input cfg_t c);
    obs_t o;
    o     = '0;
    o.hs  = ~c.hp;
    o.vs  = ~c.vp;
    o.hb  = 1'b1;
    o.vb  = 1'b1;
    return o;
  endfunction

  function automatic obs_t scan_obs(input cfg_t c, input int t);
    int   ht, vt, p, h, v;
    obs_t o;
    ht    = c.ha + c.hf + c.hsw + c.hbp;
    vt    = c.va + c.vf + c.vsw + c.vbp;
    p     = t / c.div;
    h     = p % ht;
    v     = (p / ht) % vt;
    o.hs  = (h >= c.ha + c.hf && h < c.ha + c.hf + c.hsw) ? c.hp : ~c.hp;
    o.vs  = (v >= c.va + c.vf && v < c.va + c.vf + c.vsw) ? c.vp : ~c.vp;
    o.hb  = (h >= c.ha);
    o.vb  = (v >= c.va);
    o.act = !o.hb && !o.vb;
    o.x   = 11'(h);
    o.y   = 11'(v);
    o.pe  = ((t % c.div) == 0);
    o.ls  = o.pe && (h == 0);
    o.fs  = o.ls && (v == 0);
    o.run = 1'b1;
    return o;
  endfunction

  task automatic model_step(input int i);
    int   mode;
    int   t;
    obs_t e;
    mode = m_mode[i];
    t    = m_t[i];
    e    = m_exp[i];
    if (rst) begin
      mode = 0;
      e    = idle_obs(cfg[i]);
    end else begin
      case (mode)
        0: begin
          e = idle_obs(cfg[i]);
          if (run_req[i]) mode = 1;
        end
        1: begin
          mode = 2;
          t    = 0;
        end
        default: t = (t + 1) % frame_len(cfg[i]);
      endcase
      if (mode == 2) begin
        e = scan_obs(cfg[i], t);
        if (t == frame_len(cfg[i]) - 1 && !m_prev[i] && !run_req[i]) mode = 0;
      end
    end
    m_mode[i] <= mode;
    m_t[i]    <= t;
    m_exp[i]  <= e;
    m_prev[i] <= run_req[i];
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) model_step(i);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) check($sformatf("model%0d", i), 32'(dut_obs[i]), 32'(m_exp[i]));
    end
  end

  // kind: 0 FrameStart, 1 LineStart, 2 LineStart on line val, 3 Running low
  task automatic wait_ev(input int inst, input int kind, input int val, input int budget,
                         output int cnt, output bit ok);
    cnt = 0;
    ok  = 1'b0;
    while (cnt < budget && !ok) begin
      @(negedge clk);
      cnt++;
      case (kind)
        0:       ok = dut_obs[inst].fs;
        1:       ok = dut_obs[inst].ls;
        2:       ok = dut_obs[inst].ls && (dut_obs[inst].y == 11'(val));
        default: ok = !dut_obs[inst].run;
      endcase
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait inst=%0d kind=%0d: no event within %0d clocks", inst, kind, budget);
    end
  endtask

  vec_t tbl [12];

  initial begin
    int   n, total, lx, ly, hsl, pel;
    bit   ok;
    obs_t o;

    cfg[0] = '{div: 2, ha: 16, hf: 3, hsw: 4, hbp: 2, va: 6, vf: 2, vsw: 2, vbp: 3, hp: 1'b0, vp: 1'b0};
    cfg[1] = '{div: 1, ha: 4, hf: 1, hsw: 2, hbp: 1, va: 3, vf: 1, vsw: 1, vbp: 1, hp: 1'b1, vp: 1'b1};
    cfg[2] = '{div: 2, ha: 800, hf: 56, hsw: 120, hbp: 64, va: 600, vf: 37, vsw: 6, vbp: 23,
               hp: 1'b0, vp: 1'b0};

    //               rst  run  hs vs  x  y  pe fs running
    tbl[0]  = '{1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1'b1, 1'b1, 0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{1'b0, 1'b1, 0, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{1'b0, 1'b1, 0, 0, 0, 0, 1, 1, 1};
    tbl[4]  = '{1'b0, 1'b1, 0, 0, 1, 0, 1, 0, 1};
    tbl[5]  = '{1'b0, 1'b1, 0, 0, 2, 0, 1, 0, 1};
    tbl[6]  = '{1'b0, 1'b1, 0, 0, 3, 0, 1, 0, 1};
    tbl[7]  = '{1'b0, 1'b1, 0, 0, 4, 0, 1, 0, 1};
    tbl[8]  = '{1'b0, 1'b1, 1, 0, 5, 0, 1, 0, 1};
    tbl[9]  = '{1'b0, 1'b1, 1, 0, 6, 0, 1, 0, 1};
    tbl[10] = '{1'b0, 1'b1, 0, 0, 7, 0, 1, 0, 1};
    tbl[11] = '{1'b0, 1'b1, 0, 0, 0, 1, 1, 0, 1};

    rst        = 1'b1;
    run_req[0] = 1'b0;
    run_req[1] = 1'b0;
    run_req[2] = 1'b0;
    @(negedge clk);
    chk_en     = 1'b1;
    run_req[0] = 1'b1;
    run_req[2] = 1'b1;

    // Vector table on the small CLKDIV=1 instance.
    for (int k = 0; k < 12; k++) begin
      rst        = tbl[k].rst;
      run_req[1] = tbl[k].run;
      @(negedge clk);
      o = dut_obs[1];
      check($sformatf("vec%0d", k),
            32'({o.hs, o.vs, o.x, o.y, o.pe, o.fs, o.run}),
            32'({tbl[k].hs, tbl[k].vs, 11'(tbl[k].x), 11'(tbl[k].y), tbl[k].pe, tbl[k].fs,
                 tbl[k].running}));
    end

    // Small instance: line/frame periods and continuous PixelEn.
    wait_ev(1, 1, 0, 20, n, ok);
    wait_ev(1, 1, 0, 20, n, ok);
    check("b_line_period", 32'(n), 32'd8);
    wait_ev(1, 0, 0, 100, n, ok);
    wait_ev(1, 0, 0, 100, n, ok);
    check("b_frame_period", 32'(n), 32'd48);
    pel = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (!dut_obs[1].pe) pel++;
    end
    check("b_pixelen_low_count", 32'(pel), 32'd0);

    // Graceful stop mid-frame: scanning must finish the frame.
    wait_ev(0, 2, 5, 2000, n, ok);
    run_req[0] = 1'b0;
    lx = -1;
    ly = -1;
    n  = 0;
    while (n < 2000 && dut_obs[0].run) begin
      lx = int'(dut_obs[0].x);
      ly = int'(dut_obs[0].y);
      @(negedge clk);
      n++;
    end
    check("a_stop_running", 32'(dut_obs[0].run), 32'd0);
    check("a_stop_last_pos", 32'({11'(lx), 11'(ly)}), 32'({11'd24, 11'd12}));
    check("a_stop_sync_idle", 32'({dut_obs[0].hs, dut_obs[0].vs}), 32'b11);

    // Stop request withdrawn before frame end: frame period unchanged.
    run_req[0] = 1'b1;
    wait_ev(0, 0, 0, 100, n, ok);
    total = 0;
    wait_ev(0, 2, 3, 1000, n, ok);
    total += n;
    run_req[0] = 1'b0;
    wait_ev(0, 2, 8, 1000, n, ok);
    total += n;
    run_req[0] = 1'b1;
    wait_ev(0, 0, 0, 1000, n, ok);
    total += n;
    check("a_frame_period_rerun", 32'(total), 32'd650);
    check("a_rerun_running", 32'(dut_obs[0].run), 32'd1);

    // Default timing: line period and HS-low clocks per line.
    wait_ev(2, 1, 0, 4200, n, ok);
    n   = 0;
    hsl = 0;
    do begin
      @(negedge clk);
      n++;
      if (!dut_obs[2].hs) hsl++;
    end while (!dut_obs[2].ls && n < 4200);
    check("c_line_period", 32'(n), 32'd2080);
    check("c_hs_low_clocks", 32'(hsl), 32'd240);

    // Reset mid-frame, then restart with Run held high.
    wait_ev(0, 2, 4, 1000, n, ok);
    repeat (20) @(negedge clk);
    check("a_pre_reset_x", 32'(dut_obs[0].x), 32'd10);
    rst = 1'b1;
    @(negedge clk);
    check("a_reset_outputs", 32'(dut_obs[0]), 32'({5'b11110, 11'd0, 11'd0, 4'b0000}));
    rst = 1'b0;
    wait_ev(0, 0, 0, 10, n, ok);
    check("a_restart_latency", 32'(n), 32'd2);

    // Randomised run/stop/reset traffic against the model.
    for (int s = 0; s < 25; s++) begin
      run_req[0] = ($urandom_range(0, 3) != 0);
      run_req[1] = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      repeat ($urandom_range(1, 300)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA/SVGA raster timing generator. It produces HS and VS, blanking flags, pixel coordinates, and strobes for downstream pixel and sprite logic, such as the pong renderer.
- Timing is set entirely by parameters and counted in pixels. An integer clock divider derives the pixel rate from CLK_100MHz.
- A Run/stop FSM starts scanning only at a frame boundary and stops only after the current frame has completed. This lets the display be gated without producing torn frames.

Parameters:
- CLKDIV, 2, system clocks per pixel (>=1); the default gives a 50 MHz pixel rate.
- H_ACTIVE, 800, visible pixels per line.
- H_FP, 56, horizontal front porch, in pixels.
- H_SYNC, 120, horizontal sync width, in pixels.
- H_BP, 64, horizontal back porch, in pixels.
- V_ACTIVE, 600, visible lines per frame.
- V_FP, 37, vertical front porch, in lines.
- V_SYNC, 6, vertical sync width, in lines.
- V_BP, 23, vertical back porch, in lines.
- HS_POL, 0, level of HS during the sync pulse (0 = active-low).
- VS_POL, 0, level of VS during the sync pulse.
- XW, 11, width of CurrentX; requires H_TOTAL-1 < 2^XW.
- YW, 11, width of CurrentY; requires V_TOTAL-1 < 2^YW.

Ports:
- CLK_100MHz  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- Run  in  1  level request to scan; stopping is graceful.
- HS  out  1  horizontal sync.
- VS  out  1  vertical sync.
- HBlank  out  1  high when h >= H_ACTIVE.
- VBlank  out  1  high when v >= V_ACTIVE.
- Active  out  1  high when neither HBlank nor VBlank is set.
- CurrentX  out  XW  horizontal pixel counter h, range 0..H_TOTAL-1.
- CurrentY  out  YW  line counter v, range 0..V_TOTAL-1.
- PixelEn  out  1  one-clock strobe on the first clock of each pixel period.
- LineStart  out  1  PixelEn qualified by h==0.
- FrameStart  out  1  PixelEn qualified by h==0 and v==0.
- Running  out  1  high while the FSM is in RUN or STOPPING.

Behaviour:
- Reset and interface: reset is Reset, synchronous, active-high; the clock is CLK_100MHz. All outputs are registered.
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1040); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 666).
- Reset values:
  - FSM goes to IDLE; divider, h and v are 0.
  - HS = !HS_POL and VS = !VS_POL.
  - HBlank = VBlank = 1; Active = 0; CurrentX = CurrentY = 0.
  - PixelEn, LineStart, FrameStart and Running are 0.
- Divider: DivCnt counts 0..CLKDIV-1 while the FSM is not in IDLE. A tick occurs when DivCnt==CLKDIV-1. With CLKDIV=1, every clock is a tick.
- Raster order: active area, then front porch, then sync, then back porch.
  - HS is in its asserted state for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - VS follows the same rule on v.
- Counters:
  - On a tick, h increments. At h==H_TOTAL-1, h wraps to 0 and v increments.
  - At v==V_TOTAL-1 with h wrapping, v wraps to 0.
  - No other wrap is permitted.
- Output alignment: outputs present (h,v) on the same edge the raster enters (h,v). Each (h,v) is therefore held for exactly CLKDIV clocks.
  - PixelEn is high on the first of those clocks only.
  - With CLKDIV=1, PixelEn is constantly high while the FSM is not in IDLE.
- FSM states:
  - IDLE: counters held at 0; outputs at their reset values.
  - IDLE to RUN: on a clock with Run=1. The next edge presents (0,0) with PixelEn=LineStart=FrameStart=1 and Running=1.
  - RUN to STOPPING: when Run=0.
  - STOPPING to RUN: when Run=1 is seen before the frame ends. The raster is undisturbed and there are no extra strobes.
  - STOPPING to IDLE: on the tick that would wrap (H_TOTAL-1, V_TOTAL-1) to (0,0). (0,0) is not presented; the outputs return to their reset values on that edge.
  - IDLE is entered only at a frame boundary, so no partial frame ever reaches the display.
- Reset mid-frame: Reset takes priority over Run and ticks. The block returns to IDLE on the next edge regardless of state.

Test Plan:
- Default parameters, Run=1 after reset:
  - FrameStart first on clock 2 after Reset drops.
  - LineStart period = 2080 clocks; FrameStart period = 1,385,280 clocks.
  - CurrentX steps 0..1039, each value held for 2 clocks.
- Horizontal timing check, default parameters:
  - HS is low exactly when CurrentX is in 856..975 (240 clocks per line).
  - HBlank rises when CurrentX = 800.
  - Active is low whenever VBlank is high.
- Vertical timing check, default parameters:
  - VS is low for CurrentY 637..642 only.
  - VBlank is high for CurrentY 600..665.
  - CurrentY wraps 665 to 0 coincident with FrameStart.
- Graceful stop:
  - Drop Run at CurrentY=300. Scanning completes through (1039,665), then Running falls and HS/VS go idle-high.
  - Repeat with Run re-raised at CurrentY=400: no stop occurs and the FrameStart period is unchanged.
- CLKDIV=1, H=4/1/2/1, V=3/1/1/1, HS_POL=VS_POL=1:
  - PixelEn is constantly high.
  - Line period = 8 clocks; HS is high at h=5,6.
  - Frame period = 48 clocks.
- Reset asserted at h=500, v=200:
  - Next edge gives all outputs at their reset values.
  - With Run held high, the restart FrameStart occurs 2 clocks after Reset is released.
